// File: rtl/okand_serial_alu.sv
// okand_serial_alu: serial opcode/operand receiver, five-op ALU and serial result/flag sender
module okand_serial_alu #(
    parameter int WIDTH     = 16,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic pc_clk,
    input  logic pc_rst,
    input  logic pc_data,
    input  logic pc_valid,
    output logic fpga_data,
    output logic fpga_valid,
    output logic fpga_busy,
    output logic l1,
    output logic l2
);
    localparam int FRAME = 3 + 2 * WIDTH;
    localparam int CW    = $clog2(FRAME + 1);
    localparam int OW    = $clog2(WIDTH + 2);
    localparam logic [1:0] RECV    = 2'd0;
    localparam logic [1:0] COMPUTE = 2'd1;
    localparam logic [1:0] SEND    = 2'd2;

    logic [1:0]       state;
    logic [CW-1:0]    in_cnt;
    logic [OW-1:0]    out_idx;
    logic [2:0]       op;
    logic [WIDTH-1:0] a, b, r, r_next;
    logic             flag, flag_next;
    logic [WIDTH:0]   sum, diff;
    logic             take, last_in, last_out, in_op, in_a;

    assign take     = (state == RECV) && pc_valid;
    assign last_in  = in_cnt == CW'(FRAME - 1);
    assign last_out = out_idx == OW'(WIDTH);
    assign in_op    = in_cnt < CW'(3);
    assign in_a     = in_cnt < CW'(3 + WIDTH);
    assign sum      = {1'b0, a} + {1'b0, b};
    assign diff     = {1'b0, a} - {1'b0, b};
    assign fpga_busy = state != RECV;
    assign l1       = (state == RECV) && (in_cnt == '0);
    assign l2       = pc_clk;

    // result and flag for the latched opcode; top bit of the widened sum/diff is carry/borrow
    always_comb begin
        r_next    = op == 3'd0 ? a & b :
                    op == 3'd1 ? a | b :
                    op == 3'd2 ? a ^ b :
                    op == 3'd3 ? sum[WIDTH-1:0] :
                    op == 3'd4 ? diff[WIDTH-1:0] : '0;
        flag_next = op < 3'd3  ? ~|r_next :
                    op == 3'd3 ? sum[WIDTH] :
                    op == 3'd4 ? diff[WIDTH] : 1'b1;
    end

    // shift accepted bits into op, then A, then B; bit count alone tracks frame position
    always_ff @(posedge pc_clk or posedge pc_rst) begin
        if (pc_rst) begin
            op <= '0;
            a  <= '0;
            b  <= '0;
        end else if (take) begin
            if (in_op)
                op <= MSB_FIRST ? {op[1:0], pc_data} : {pc_data, op[2:1]};
            else if (in_a)
                a <= MSB_FIRST ? {a[WIDTH-2:0], pc_data} : {pc_data, a[WIDTH-1:1]};
            else
                b <= MSB_FIRST ? {b[WIDTH-2:0], pc_data} : {pc_data, b[WIDTH-1:1]};
        end
    end

    // sequencing: count input bits, latch result for one cycle, then stream R and FLAG
    always_ff @(posedge pc_clk or posedge pc_rst) begin
        if (pc_rst) begin
            state      <= RECV;
            in_cnt     <= '0;
            out_idx    <= '0;
            r          <= '0;
            flag       <= 1'b0;
            fpga_data  <= 1'b0;
            fpga_valid <= 1'b0;
        end else if (state == RECV) begin
            fpga_valid <= 1'b0;
            if (pc_valid) begin
                in_cnt <= last_in ? '0 : in_cnt + 1'b1;
                state  <= last_in ? COMPUTE : RECV;
            end
        end else if (state == COMPUTE) begin
            r          <= r_next;
            flag       <= flag_next;
            out_idx    <= '0;
            fpga_valid <= 1'b0;
            state      <= SEND;
        end else if (state == SEND) begin
            fpga_valid <= 1'b1;
            fpga_data  <= last_out ? flag : (MSB_FIRST ? r[WIDTH-1] : r[0]);
            r          <= MSB_FIRST ? r << 1 : r >> 1;
            out_idx    <= out_idx + 1'b1;
            state      <= last_out ? RECV : SEND;
        end else begin
            fpga_valid <= 1'b0;
            state      <= RECV;
        end
    end
endmodule
